round_judge: RTL and testbench

//  Producer side of the scoreboard display interface: runs the game rounds and drives score/pattern/C.
//  Per round: presents a one-hot target pattern, samples the 4 finger buttons, judges hit/miss, updates score.
//  C pulses for one clk whenever score or pattern changes; the display latches on C.

---
 rtl/round_judge_pkg.sv | 28 ++
 rtl/round_judge_btn_sync.sv | 32 +++
 rtl/round_judge.sv | 164 ++++++++++++++++
 tb/tb_round_judge.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/round_judge_pkg.sv
// round_judge_pkg: shared types and helpers for the round_judge game block.
//   state_e    : FSM state encoding (IDLE/GAP/SHOW/OVER)
//   LFSR_TAPS  : feedback mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   PAT_NONE   : blank pattern shown between rounds
//   lfsr_step  : one LFSR shift
//   pat_onehot : 2-bit index -> one-hot finger pattern
package round_judge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GAP  = 2'd1,
      ST_SHOW = 2'd2,
      ST_OVER = 2'd3
   } state_e;

   // Taps 8,6,5,4 map to bits 7,5,4,3.
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam logic [3:0] PAT_NONE  = 4'b0000;

   function automatic logic [7:0] lfsr_step(input logic [7:0] q);
      return {q[6:0], ^(q & LFSR_TAPS)};
   endfunction

   function automatic logic [3:0] pat_onehot(input logic [1:0] sel);
      return 4'b0001 << sel;
   endfunction

endpackage

// File: rtl/round_judge_btn_sync.sv
// round_judge_btn_sync: W-bit two-flop synchroniser with rising-edge detect.
//   clk_i  : system clock
//   res_i  : synchronous active-high reset, clears all stages
//   d_i    : asynchronous inputs
//   rise_o : one-clk pulse per 0->1 transition of each bit
module round_judge_btn_sync #(
   parameter int unsigned W = 4
) (
   input  logic         clk_i,
   input  logic         res_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] s1_q, s2_q, s3_q;

   always_ff @(posedge clk_i) begin
      if (res_i) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // s3 is only an edge-history flop; s2 is the first metastability-safe stage.
   assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/round_judge.sv
// round_judge: runs game rounds for the scoreboard display.
// Shows a one-hot target pattern, judges the first finger press as hit/miss,
// keeps score and miss count, and strobes C_o whenever displayed data changes.
//   clk_i     : system clock
//   res_i     : synchronous active-high reset
//   tick_i    : one-clk time-base strobe for gap/window timing
//   start_i   : level; rising edge starts a game from IDLE or OVER
//   btn_i     : raw finger buttons (asynchronous, active-high)
//   pattern_o : target pattern, one-hot in SHOW, 0 otherwise
//   score_o   : score, saturates at MAX_SCORE
//   C_o       : one-clk latch strobe for the display
//   misses_o  : misses in the current game
//   over_o    : high while the game is over
module round_judge
   import round_judge_pkg::*;
#(
   parameter int unsigned WINDOW_TICKS = 16,
   parameter int unsigned GAP_TICKS    = 4,
   parameter int unsigned MAX_MISSES   = 3,
   parameter int unsigned MAX_SCORE    = 99,
   parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
   input  logic       clk_i,
   input  logic       res_i,
   input  logic       tick_i,
   input  logic       start_i,
   input  logic [3:0] btn_i,
   output logic [3:0] pattern_o,
   output logic [7:0] score_o,
   output logic       C_o,
   output logic [3:0] misses_o,
   output logic       over_o
);

   logic [3:0] press;
   logic [0:0] start_rise;

   round_judge_btn_sync #(.W(4)) u_btn_sync (
      .clk_i  (clk_i),
      .res_i  (res_i),
      .d_i    (btn_i),
      .rise_o (press)
   );

   round_judge_btn_sync #(.W(1)) u_start_sync (
      .clk_i  (clk_i),
      .res_i  (res_i),
      .d_i    (start_i),
      .rise_o (start_rise)
   );

   state_e     state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [3:0] pat_q, pat_d;
   logic [7:0] score_q, score_d;
   logic [3:0] misses_q, misses_d;
   logic       c_q, c_d;

   // 9-bit so the compare against the tick limits cannot overflow.
   logic [8:0] timer_inc;
   logic [7:0] timer_sat;
   logic [3:0] misses_inc;
   logic       do_miss;

   assign timer_inc  = {1'b0, timer_q} + 9'd1;
   assign timer_sat  = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
   assign misses_inc = misses_q + 4'd1;

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      lfsr_d   = lfsr_q;
      pat_d    = pat_q;
      score_d  = score_q;
      misses_d = misses_q;
      c_d      = 1'b0;
      do_miss  = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_OVER: begin
            pat_d = PAT_NONE;
            if (start_rise[0]) begin
               lfsr_d   = LFSR_SEED;
               score_d  = '0;
               misses_d = '0;
               timer_d  = '0;
               c_d      = 1'b1;
               state_d  = ST_GAP;
            end
         end
         ST_GAP: begin
            pat_d = PAT_NONE;
            if (tick_i) begin
               if (timer_inc >= 9'(GAP_TICKS)) begin
                  pat_d   = pat_onehot(lfsr_q[1:0]);
                  lfsr_d  = lfsr_step(lfsr_q);
                  timer_d = '0;
                  c_d     = 1'b1;
                  state_d = ST_SHOW;
               end else begin
                  timer_d = timer_sat;
               end
            end
         end
         ST_SHOW: begin
            // Press is checked first so a press on the final tick is judged.
            if (press != 4'b0000) begin
               if (press == pat_q) begin
                  if (score_q < 8'(MAX_SCORE))
                     score_d = score_q + 8'd1;
                  pat_d   = PAT_NONE;
                  timer_d = '0;
                  c_d     = 1'b1;
                  state_d = ST_GAP;
               end else begin
                  do_miss = 1'b1;
               end
            end else if (tick_i) begin
               if (timer_inc >= 9'(WINDOW_TICKS))
                  do_miss = 1'b1;
               else
                  timer_d = timer_sat;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (do_miss) begin
         misses_d = misses_inc;
         pat_d    = PAT_NONE;
         timer_d  = '0;
         c_d      = 1'b1;
         state_d  = (misses_inc == 4'(MAX_MISSES)) ? ST_OVER : ST_GAP;
      end
   end

   always_ff @(posedge clk_i) begin
      if (res_i) begin
         state_q  <= ST_IDLE;
         timer_q  <= '0;
         lfsr_q   <= LFSR_SEED;
         pat_q    <= PAT_NONE;
         score_q  <= '0;
         misses_q <= '0;
         c_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         lfsr_q   <= lfsr_d;
         pat_q    <= pat_d;
         score_q  <= score_d;
         misses_q <= misses_d;
         c_q      <= c_d;
      end
   end

   assign pattern_o = pat_q;
   assign score_o   = score_q;
   assign C_o       = c_q;
   assign misses_o  = misses_q;
   assign over_o    = (state_q == ST_OVER);

endmodule

// File: tb/tb_round_judge.sv
module tb_round_judge;

   logic       clk = 1'b0;
   logic       res, tick, start;
   logic [3:0] btn;

   logic [3:0] pattern, misses, pattern2, misses2;
   logic [7:0] score, score2;
   logic       c, over, c2, over2;

   int vectors = 0;
   int errs    = 0;
   int c_cnt   = 0;
   int c2_cnt  = 0;
   int c_run   = 0;
   int c2_run  = 0;
   int c_maxrun = 0;
   int c2b;

   round_judge dut (
      .clk_i(clk), .res_i(res), .tick_i(tick), .start_i(start), .btn_i(btn),
      .pattern_o(pattern), .score_o(score), .C_o(c), .misses_o(misses), .over_o(over)
   );

   round_judge #(.MAX_SCORE(2)) dut2 (
      .clk_i(clk), .res_i(res), .tick_i(tick), .start_i(start), .btn_i(btn),
      .pattern_o(pattern2), .score_o(score2), .C_o(c2), .misses_o(misses2), .over_o(over2)
   );

   always #5 clk = ~clk;

   // C pulse counting and longest-run tracking.
   always @(posedge clk) begin
      if (c) c_cnt++;
      if (c2) c2_cnt++;
      c_run  = c  ? c_run + 1  : 0;
      c2_run = c2 ? c2_run + 1 : 0;
      if (c_run > c_maxrun)  c_maxrun = c_run;
      if (c2_run > c_maxrun) c_maxrun = c2_run;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clk1();
      @(negedge clk);
   endtask

   task automatic tick1();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick1();
   endtask

   task automatic press(input logic [3:0] p);
      btn = p;
      repeat (4) clk1();
      btn = 4'b0000;
      repeat (3) clk1();
   endtask

   initial begin
      res = 1'b1; tick = 1'b0; start = 1'b0; btn = 4'b0000;

      // 1: reset holds everything at zero even with buttons toggling
      for (int i = 0; i < 3; i++) begin
         btn = (i % 2 == 0) ? 4'hF : 4'h0;
         clk1();
      end
      chk("rst_pattern", pattern, 4'b0000);
      chk("rst_score",   score,   8'd0);
      chk("rst_misses",  misses,  4'd0);
      chk("rst_over",    over,    1'b0);
      chk("rst_c",       c_cnt,   0);
      btn = 4'b0000;
      res = 1'b0;
      repeat (5) clk1();
      chk("idle_pattern", pattern, 4'b0000);
      chk("idle_c",       c_cnt,   0);

      // 2: start, first pattern from seed A5, hit
      start = 1'b1;
      repeat (4) clk1();
      chk("start_c",      c_cnt,  1);
      chk("start_score",  score,  8'd0);
      ticks(3);
      chk("gap3_pattern", pattern, 4'b0000);
      tick1();
      chk("r1_pattern",   pattern, 4'b0010);
      chk("r1_c",         c_cnt,   2);
      press(4'b0010);
      chk("hit_score",    score,   8'd1);
      chk("hit_pattern",  pattern, 4'b0000);
      chk("hit_c",        c_cnt,   3);

      // 3: multi-bit press is a miss
      ticks(4);
      chk("r2_pattern",   pattern, 4'b0100);
      press(4'b0011);
      chk("wrong_misses", misses,  4'd1);
      chk("wrong_score",  score,   8'd1);
      chk("wrong_c",      c_cnt,   5);

      // 4: timeout after 16 ticks, not 15
      ticks(4);
      chk("r3_pattern",   pattern, 4'b0010);
      ticks(15);
      chk("t15_pattern",  pattern, 4'b0010);
      chk("t15_misses",   misses,  4'd1);
      tick1();
      chk("to_pattern",   pattern, 4'b0000);
      chk("to_misses",    misses,  4'd2);
      chk("to_c",         c_cnt,   7);

      // 6a: press coincides with the final window tick -> press wins
      ticks(4);
      chk("r4_pattern",   pattern, 4'b0100);
      ticks(15);
      btn = 4'b0100;
      clk1(); clk1();
      tick = 1'b1;
      clk1();
      tick = 1'b0;
      clk1(); clk1();
      btn = 4'b0000;
      chk("edge_score",   score,   8'd2);
      chk("edge_misses",  misses,  4'd2);
      chk("edge_c",       c_cnt,   9);

      // 6c: button held from GAP into SHOW -> no press, timeout miss -> OVER
      btn = 4'b0001;
      ticks(4);
      chk("r5_pattern",   pattern, 4'b0001);
      ticks(15);
      chk("held_pattern", pattern, 4'b0001);
      tick1();
      chk("over_misses",  misses,  4'd3);
      chk("over_flag",    over,    1'b1);
      chk("over_pattern", pattern, 4'b0000);
      chk("over_score",   score,   8'd2);
      chk("over_c",       c_cnt,   11);
      btn = 4'b0000;

      // 4b: restart from OVER
      start = 1'b0;
      repeat (4) clk1();
      start = 1'b1;
      repeat (4) clk1();
      chk("rs_score",  score,  8'd0);
      chk("rs_misses", misses, 4'd0);
      chk("rs_over",   over,   1'b0);
      chk("rs_c",      c_cnt,  12);
      ticks(4);
      chk("rs_pattern", pattern, 4'b0010);

      // 6b: reset in the middle of SHOW
      res = 1'b1;
      repeat (2) clk1();
      chk("mres_pattern", pattern, 4'b0000);
      chk("mres_c",       c_cnt,   13);
      start = 1'b0;
      res = 1'b0;
      repeat (4) clk1();
      chk("mres_idle",    pattern, 4'b0000);
      chk("mres_c2",      c_cnt,   13);

      // 5: saturation on the MAX_SCORE=2 instance
      c2b = c2_cnt;
      start = 1'b1;
      repeat (4) clk1();
      ticks(4);
      chk("s1_pattern", pattern2, 4'b0010);
      press(4'b0010);
      chk("s1_score",   score2,   8'd1);
      chk("s1_c",       c2_cnt - c2b, 3);
      ticks(4);
      chk("s2_pattern", pattern2, 4'b0100);
      press(4'b0100);
      chk("s2_score",   score2,   8'd2);
      chk("s2_c",       c2_cnt - c2b, 5);
      ticks(4);
      chk("s3_pattern", pattern2, 4'b0010);
      press(4'b0010);
      chk("s3_score",   score2,   8'd2);
      chk("s3_c",       c2_cnt - c2b, 7);
      chk("s3_free_score", score, 8'd3);

      chk("c_width", c_maxrun, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
